// File: rtl/dmem_pkg.sv
// Shared definitions for the load/store data memory: access-size encodings,
// controller states and lane geometry.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    function automatic int lane_count(input int xlen, input int mem_width);
        return xlen / mem_width;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Selects the addressed bytes of a registered memory word and sign- or
// zero-extends them to XLEN according to the load funct3.
module dmem_load_align
    import dmem_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = 2
) (
    input  logic [XLEN-1:0]  word,
    input  logic [OFF_W-1:0] offset,
    input  logic [2:0]       funct3,
    output logic [XLEN-1:0]  data
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = word >> {offset, 3'b000};
        data    = '0;
        case (funct3)
            F3_B:    data = XLEN'($signed(shifted[7:0]));
            F3_H:    data = XLEN'($signed(shifted[15:0]));
            F3_W:    data = XLEN'($signed(shifted[31:0]));
            F3_BU:   data = XLEN'(shifted[7:0]);
            F3_HU:   data = XLEN'(shifted[15:0]);
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Little-endian byte-addressed data memory with RISC-V load/store semantics,
// a valid/ready request port, one-cycle registered response and a
// post-reset hardware clear of the whole array.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MEM_WIDTH = 8,
    parameter int MEM_DEPTH = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] aluout,
    input  logic [XLEN-1:0] rs2_out,
    output logic            rsp_valid,
    output logic [XLEN-1:0] dmem_out,
    output logic            rsp_err
);

    localparam int LANES = lane_count(XLEN, MEM_WIDTH);
    localparam int BYTES = XLEN / 8;
    localparam int WORDS = MEM_DEPTH / BYTES;
    localparam int OFF_W = $clog2(BYTES);
    localparam int AW    = $clog2(MEM_DEPTH);
    localparam int IDX_W = AW - OFF_W;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   clr_idx;
    logic               clr_we;

    logic [OFF_W-1:0]   off_p0;
    logic [IDX_W-1:0]   idx_p0;
    logic [LANES-1:0]   size_mask_p0, wmask_p0;
    logic [XLEN-1:0]    wdata_p0;
    logic               legal_p0, misaligned_p0, in_range_p0, err_p0;
    logic               accept_p0, st_en_p0;

    logic [XLEN-1:0]    mem [WORDS];

    logic [XLEN-1:0]    rdata_p1;
    logic [OFF_W-1:0]   off_p1;
    logic [2:0]         f3_p1;
    logic               vld_p1, err_p1, ld_p1;
    logic [XLEN-1:0]    aligned_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            clr_idx <= '0;
        end else begin
            state_q <= state_d;
            if (clr_we) clr_idx <= clr_idx + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        clr_we    = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                if (clr_idx == IDX_W'(WORDS - 1)) state_d = READY;
            end
            READY:   req_ready = 1'b1;
            default: state_d = CLEAR;
        endcase
    end

    // ---- p0: request decode and store lane preparation ----
    always_comb begin
        off_p0        = aluout[OFF_W-1:0];
        idx_p0        = aluout[AW-1:OFF_W];
        in_range_p0   = aluout < XLEN'(MEM_DEPTH);
        legal_p0      = 1'b0;
        misaligned_p0 = 1'b0;
        size_mask_p0  = '0;
        case (req_funct3)
            F3_B: begin
                legal_p0     = 1'b1;
                size_mask_p0 = LANES'(1);
            end
            F3_H: begin
                legal_p0      = 1'b1;
                size_mask_p0  = LANES'(3);
                misaligned_p0 = off_p0[0];
            end
            F3_W: begin
                legal_p0      = 1'b1;
                size_mask_p0  = LANES'(15);
                misaligned_p0 = off_p0[1:0] != 2'b00;
            end
            F3_BU: begin
                legal_p0     = !req_we;
                size_mask_p0 = LANES'(1);
            end
            F3_HU: begin
                legal_p0      = !req_we;
                size_mask_p0  = LANES'(3);
                misaligned_p0 = off_p0[0];
            end
            default: legal_p0 = 1'b0;
        endcase
        err_p0    = !legal_p0 || misaligned_p0 || !in_range_p0;
        // A request coinciding with reset is dropped so nothing survives it.
        accept_p0 = req_valid && req_ready && !rst;
        st_en_p0  = accept_p0 && req_we && !err_p0;
        wmask_p0  = size_mask_p0 << off_p0;
        wdata_p0  = rs2_out << {off_p0, 3'b000};
    end

    // Clear and store writes never coincide: stores are only accepted in READY.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end else if (st_en_p0) begin
            for (int l = 0; l < LANES; l++) begin
                if (wmask_p0[l]) mem[idx_p0][l*MEM_WIDTH +: MEM_WIDTH] <= wdata_p0[l*MEM_WIDTH +: MEM_WIDTH];
            end
        end
    end

    // ---- p1: registered read word and response control ----
    always_ff @(posedge clk) begin
        if (accept_p0) begin
            rdata_p1 <= mem[idx_p0];
            off_p1   <= off_p0;
            f3_p1    <= req_funct3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
            ld_p1  <= 1'b0;
        end else begin
            vld_p1 <= accept_p0;
            err_p1 <= accept_p0 && err_p0;
            ld_p1  <= accept_p0 && !req_we && !err_p0;
        end
    end

    dmem_load_align #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_align (
        .word   (rdata_p1),
        .offset (off_p1),
        .funct3 (f3_p1),
        .data   (aligned_p1)
    );

    assign rsp_valid = vld_p1;
    assign rsp_err   = err_p1;
    assign dmem_out  = ld_p1 ? aligned_p1 : '0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: table-driven request stream with a response scoreboard,
// plus hand-written reset/clear sequences.
module tb_dmem_lsu;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] aluout;
    logic [31:0] rs2_out;
    logic        rsp_valid;
    logic [31:0] dmem_out;
    logic        rsp_err;

    always #5 clk = ~clk;

    dmem_lsu #(
        .XLEN      (32),
        .MEM_WIDTH (8),
        .MEM_DEPTH (1024)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .aluout     (aluout),
        .rs2_out    (rs2_out),
        .rsp_valid  (rsp_valid),
        .dmem_out   (dmem_out),
        .rsp_err    (rsp_err)
    );

    typedef struct packed {
        logic        err;
        logic [31:0] data;
        logic [7:0]  tag;
    } exp_t;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        e_err;
        logic [31:0] e_data;
    } vec_t;

    localparam int NVEC = 22;

    exp_t sb_q[$];
    vec_t vecs[NVEC];
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t e;

    // Each accepted request must produce exactly one response right after its accept edge.
    always @(posedge clk) begin
        #2;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_tests++;
            if (rsp_valid !== 1'b1 || rsp_err !== e.err || dmem_out !== e.data) begin
                n_fail++;
                $display("FAIL rsp tag=%0d: valid=%0b err=%0b data=%h, required valid=1 err=%0b data=%h",
                         e.tag, rsp_valid, rsp_err, dmem_out, e.err, e.data);
            end
        end else if (rsp_valid !== 1'b0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_rsp: valid=%0b err=%0b data=%h, required valid=0", rsp_valid, rsp_err, dmem_out);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                         input logic e_err, input logic [31:0] e_data, input logic [7:0] tag);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        aluout     = a;
        rs2_out    = d;
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL drive_ready tag=%0d: req_ready=%0b, required 1", tag, req_ready);
        end else begin
            sb_q.push_back('{e_err, e_data, tag});
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic count_clear(output int cnt);
        cnt = 0;
        while (req_ready !== 1'b1 && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cnt;
        vecs[0]  = '{1'b1, F3_W,   32'h008, 32'hDEADBEEF, 1'b0, 32'h00000000};
        vecs[1]  = '{1'b0, F3_B,   32'h008, 32'h0,        1'b0, 32'hFFFFFFEF};
        vecs[2]  = '{1'b0, F3_BU,  32'h00B, 32'h0,        1'b0, 32'h000000DE};
        vecs[3]  = '{1'b0, F3_H,   32'h00A, 32'h0,        1'b0, 32'hFFFFDEAD};
        vecs[4]  = '{1'b0, F3_HU,  32'h00A, 32'h0,        1'b0, 32'h0000DEAD};
        vecs[5]  = '{1'b1, F3_W,   32'h004, 32'hAAAAAAAA, 1'b0, 32'h00000000};
        vecs[6]  = '{1'b1, F3_B,   32'h005, 32'h12345655, 1'b0, 32'h00000000};
        vecs[7]  = '{1'b1, F3_H,   32'h006, 32'hABCD1234, 1'b0, 32'h00000000};
        vecs[8]  = '{1'b0, F3_W,   32'h004, 32'h0,        1'b0, 32'h123455AA};
        vecs[9]  = '{1'b0, F3_W,   32'h002, 32'h0,        1'b1, 32'h00000000};
        vecs[10] = '{1'b0, F3_H,   32'h001, 32'h0,        1'b1, 32'h00000000};
        vecs[11] = '{1'b1, F3_W,   32'h400, 32'hFFFFFFFF, 1'b1, 32'h00000000};
        vecs[12] = '{1'b0, 3'b011, 32'h000, 32'h0,        1'b1, 32'h00000000};
        vecs[13] = '{1'b1, F3_BU,  32'h000, 32'hFFFFFFFF, 1'b1, 32'h00000000};
        vecs[14] = '{1'b0, F3_W,   32'h000, 32'h0,        1'b0, 32'h00000000};
        vecs[15] = '{1'b1, F3_W,   32'h008, 32'hDDDDAAAA, 1'b0, 32'h00000000};
        vecs[16] = '{1'b0, F3_W,   32'h008, 32'h0,        1'b0, 32'hDDDDAAAA};
        vecs[17] = '{1'b0, F3_H,   32'h00A, 32'h0,        1'b0, 32'hFFFFDDDD};
        vecs[18] = '{1'b0, F3_BU,  32'h009, 32'h0,        1'b0, 32'h000000AA};
        vecs[19] = '{1'b0, F3_W,   32'h3FC, 32'h0,        1'b0, 32'h00000000};
        vecs[20] = '{1'b0, F3_B,   32'h3FF, 32'h0,        1'b0, 32'h00000000};
        vecs[21] = '{1'b0, F3_W,   32'h404, 32'h0,        1'b1, 32'h00000000};

        rst        = 1'b1;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = F3_W;
        aluout     = 32'h0;
        rs2_out    = 32'h0;

        @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_err", 32'(rsp_err), 32'h0);
        check("reset_dmem_out", dmem_out, 32'h0);
        rst = 1'b0;

        // req_valid held high throughout the clear; the first LW @0 goes in once ready rises.
        count_clear(cnt);
        check("clear_cycles", 32'(cnt), 32'd256);
        if (req_ready === 1'b1) sb_q.push_back('{1'b0, 32'h0, 8'd200});

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].e_err, vecs[i].e_data, 8'(i));
        end
        idle(3);

        // Reset in the middle of a stream: the load presented with rst is dropped.
        drive(1'b1, F3_W, 32'h0, 32'hFFFFFFFF, 1'b0, 32'h0, 8'd100);
        @(negedge clk);
        rst        = 1'b1;
        req_we     = 1'b0;
        req_funct3 = F3_W;
        aluout     = 32'h0;
        req_valid  = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 1'b0;
        check("rst_drop_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        count_clear(cnt);
        check("clear_cycles_after_rst", 32'(cnt), 32'd256);

        drive(1'b0, F3_W, 32'h000, 32'h0, 1'b0, 32'h00000000, 8'd101);
        drive(1'b0, F3_W, 32'h008, 32'h0, 1'b0, 32'h00000000, 8'd102);
        drive(1'b0, F3_W, 32'h004, 32'h0, 1'b0, 32'h00000000, 8'd103);
        idle(4);
        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
